// File: rtl/maze_round_ctrl.sv
// Round sequencer for the VGA maze game: maze load, player reset,
// seconds countdown, score and hard-mode lives.
module maze_round_ctrl #(
    parameter int          ROUND_TIME  = 25,
    parameter int          LIVES       = 3,
    parameter int          HOLD_FRAMES = 30,
    parameter logic [15:0] SCORE_MAX   = 16'hFFFF
) (
    input  logic        in_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        posr,
    input  logic        hard_mode,
    input  logic        frame_tick,
    input  logic        sec_tick,
    input  logic        hit_wall,
    input  logic        hit_flag,
    output logic        maze_load,
    output logic        pos_reset,
    output logic        move_en,
    output logic [7:0]  timer,
    output logic [15:0] score,
    output logic [3:0]  lives,
    output logic        hard_q,
    output logic [2:0]  state,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PLAY    = 3'd2,
        S_HIT     = 3'd3,
        S_WIN     = 3'd4,
        S_TIMEOUT = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    localparam logic [7:0] RT8    = 8'(ROUND_TIME);
    localparam logic [3:0] LIVES4 = 4'(LIVES);
    // A zero hold length would never let the hold states exit.
    localparam logic [7:0] HOLD_EFF =
        (HOLD_FRAMES == 0) ? 8'd1 : 8'(HOLD_FRAMES);

    state_t      cur, nxt;
    logic [7:0]  timer_r, timer_n;
    logic [15:0] score_r, score_n;
    logic [3:0]  lives_r, lives_n;
    logic        hard_r, hard_n;
    logic [7:0]  hold_r, hold_n;
    logic        load_n, posr_n, move_n, over_n;

    logic [16:0] score_sum;
    logic [15:0] score_sat;
    logic [8:0]  hold_inc;
    logic        hold_done;
    logic        nxt_hold;
    logic [3:0]  lives_dec;

    // Saturating score increment, doubled for a hard-mode round.
    always_comb begin
        score_sum = {1'b0, score_r} + (hard_r ? 17'd2 : 17'd1);
        if (score_sum > {1'b0, SCORE_MAX})
            score_sat = SCORE_MAX;
        else
            score_sat = score_sum[15:0];
        hold_inc  = {1'b0, hold_r} + 9'd1;
        hold_done = (hold_inc >= {1'b0, HOLD_EFF});
        lives_dec = (lives_r != 4'd0) ? lives_r - 4'd1 : 4'd0;
    end

    // Next state and next values of every registered output.
    always_comb begin
        nxt     = cur;
        timer_n = timer_r;
        score_n = score_r;
        lives_n = lives_r;
        hard_n  = hard_r;
        hold_n  = hold_r;

        unique case (cur)
            S_IDLE, S_OVER: begin
                if (start) begin
                    nxt     = S_LOAD;
                    score_n = 16'd0;
                    lives_n = LIVES4;
                end
            end
            S_LOAD: begin
                hard_n = hard_mode;
                nxt    = S_PLAY;
            end
            S_PLAY: begin
                if (posr) begin
                    nxt = S_LOAD;
                end else if (frame_tick && hit_flag) begin
                    nxt     = S_WIN;
                    score_n = score_sat;
                end else if (sec_tick && timer_r == 8'd1) begin
                    nxt     = S_TIMEOUT;
                    timer_n = 8'd0;
                    if (hard_r)
                        lives_n = lives_dec;
                end else begin
                    if (sec_tick && timer_r != 8'd0)
                        timer_n = timer_r - 8'd1;
                    // Normal mode leaves wall blocking to the datapath.
                    if (frame_tick && hit_wall && hard_r) begin
                        nxt     = S_HIT;
                        lives_n = lives_dec;
                    end
                end
            end
            S_HIT, S_WIN, S_TIMEOUT: begin
                if (frame_tick) begin
                    hold_n = hold_inc[7:0];
                    if (hold_done) begin
                        if (cur == S_WIN)
                            nxt = S_LOAD;
                        else if (lives_r == 4'd0)
                            nxt = S_OVER;
                        else if (cur == S_HIT)
                            nxt = S_PLAY;
                        else
                            nxt = S_LOAD;
                    end
                end
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase

        // Every round start and every return from a hit reloads the clock.
        if (nxt == S_LOAD)
            timer_n = RT8;
        if (cur == S_HIT && nxt == S_PLAY)
            timer_n = RT8;

        // The hold counter only ever counts within one hold state.
        if (nxt != cur)
            hold_n = 8'd0;

        nxt_hold = (nxt == S_HIT) || (nxt == S_WIN) ||
                   (nxt == S_TIMEOUT);
        load_n   = (nxt == S_LOAD);
        posr_n   = load_n || (nxt_hold && cur == S_PLAY);
        move_n   = (nxt == S_PLAY);
        over_n   = (nxt == S_OVER);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge in_clk) begin
        if (!reset) begin
            cur       <= S_IDLE;
            timer_r   <= RT8;
            score_r   <= 16'd0;
            lives_r   <= LIVES4;
            hard_r    <= 1'b0;
            hold_r    <= 8'd0;
            maze_load <= 1'b0;
            pos_reset <= 1'b0;
            move_en   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            cur       <= nxt;
            timer_r   <= timer_n;
            score_r   <= score_n;
            lives_r   <= lives_n;
            hard_r    <= hard_n;
            hold_r    <= hold_n;
            maze_load <= load_n;
            pos_reset <= posr_n;
            move_en   <= move_n;
            game_over <= over_n;
        end
    end

    assign timer  = timer_r;
    assign score  = score_r;
    assign lives  = lives_r;
    assign hard_q = hard_r;
    assign state  = cur;

endmodule

// File: doc/maze_round_ctrl.md
Name: maze_round_ctrl

Overview:
- Round sequencer for the VGA maze game.
- Decides when a new maze is latched from the wall LFSRs and when the player square is returned to the start cell.
- Owns the seconds countdown, the score and (in hard mode) a lives counter.
- Consumes collision/flag flags from the render/collision datapath; drives its load, position-reset and movement-enable controls plus the 7-seg timer/score fields.

Parameters:
- ROUND_TIME, 25, seconds per round (timer reload value, fits 8 bits)
- LIVES, 3, lives granted per game in hard mode (fits 4 bits)
- HOLD_FRAMES, 30, frame_tick count the player is frozen after a hit/win/timeout (fits 8 bits)
- SCORE_MAX, 16'hFFFF, score saturation value

Ports:
- in_clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-low reset
- start  input  1  1-cycle pulse: begin game from IDLE or OVER
- posr  input  1  level/pulse: player-requested restart of current round
- hard_mode  input  1  dark-souls mode select, sampled only in LOAD
- frame_tick  input  1  1-cycle pulse once per video frame (vcnt==481, hcnt==0)
- sec_tick  input  1  1-cycle pulse once per second
- hit_wall  input  1  player overlaps an enabled wall or border this frame
- hit_flag  input  1  player overlaps end flag this frame
- maze_load  output  1  1-cycle pulse: latch new wall pattern
- pos_reset  output  1  1-cycle pulse: return player to start position
- move_en  output  1  player position may update
- timer  output  8  seconds remaining
- score  output  16  rounds won (weighted)
- lives  output  4  lives remaining (hard mode; LIVES held in normal mode)
- hard_q  output  1  latched mode for current round
- state  output  3  IDLE=0, LOAD=1, PLAY=2, HIT=3, WIN=4, TIMEOUT=5, OVER=6
- game_over  output  1  high while in OVER

Behaviour:
- Reset (reset==0 at posedge) values:
  - state=IDLE, timer=ROUND_TIME, score=0, lives=LIVES, hard_q=0.
  - maze_load=pos_reset=move_en=game_over=0; hold counter=0.
  - Reset has priority over every other input, including mid-hold.
- All outputs are registered. Pulses are exactly one in_clk wide.
- IDLE: all outputs idle. start -> LOAD.
- LOAD (exactly 1 cycle):
  - maze_load=1, pos_reset=1, timer<=ROUND_TIME, hard_q<=hard_mode.
  - Next state PLAY.
- PLAY: move_en=1. Evaluated each cycle, priority highest first:
  - 1. posr=1 -> LOAD. Score and lives unchanged.
  - 2. frame_tick & hit_flag -> WIN.
    - score += (hard_q ? 2 : 1), saturating at SCORE_MAX.
  - 3. sec_tick & timer==1 -> timer<=0, TIMEOUT.
    - Any other sec_tick decrements timer.
  - 4. frame_tick & hit_wall & hard_q -> HIT, lives -= 1.
    - In normal mode hit_wall is ignored (the datapath blocks movement instead).
  - hit_flag/hit_wall are only sampled on frame_tick cycles.
  - Simultaneous flag+wall on one frame counts as WIN.
- HIT/WIN/TIMEOUT (hold states):
  - move_en=0. pos_reset=1 on the entry cycle. Hold counter cleared on entry.
  - Counter increments on each frame_tick. Timer frozen; sec_tick ignored.
  - posr ignored during hold.
  - Exit when counter reaches HOLD_FRAMES:
    - HIT: lives==0 -> OVER; else PLAY with timer<=ROUND_TIME and the same maze (no maze_load).
    - WIN -> LOAD (new maze).
    - TIMEOUT: if hard_q, lives -= 1 on entry. Exit: lives==0 -> OVER, else LOAD.
- OVER: game_over=1, move_en=0, score and lives hold.
  - start -> score<=0, lives<=LIVES, then LOAD.
- Lives never underflow: decrement only when lives>0.
- hard_mode changes outside LOAD have no effect until the next LOAD.
- start is ignored outside IDLE/OVER.
- HOLD_FRAMES=0 is treated as 1.

Test Plan:
- Reset low 2 cycles, then start pulse -> state 0->1->2 on consecutive cycles; maze_load and pos_reset each high for exactly 1 cycle; timer=25, score=0, lives=3.
- PLAY, normal mode, 25 sec_ticks with no hits -> timer 25..1 then 0, state=TIMEOUT. After 30 frame_ticks -> LOAD pulse, timer=25, lives still 3.
- PLAY, hard_mode=1 latched, frame_tick with hit_flag=1 and hit_wall=1 together -> WIN, score=2, lives=3, move_en=0 for 30 frames, then LOAD.
- Hard mode, 3 wall hits each followed by hold -> lives 2,1,0. Third hold ends in OVER with game_over=1. start -> score=0, lives=3, LOAD.
- Normal mode, hit_wall on frame_tick -> stays PLAY, lives=3. posr mid-round (timer=12) -> LOAD, timer=25, score unchanged.
- Score preset via 65535 wins (or forced) -> further win keeps score=16'hFFFF. Reset asserted during WIN hold -> all outputs return to reset values next edge.
